// File: rtl/exec_stage_pkg.sv
// ============================================================================
// exec_stage_pkg : ALU opcodes, flag bit indices and op classification
// Rev 1.0
// ============================================================================
`default_nettype none

package exec_stage_pkg;

  localparam int FLAG_W     = 7;
  localparam int FLAG_OVF   = 6;
  localparam int FLAG_ABOVE = 5;
  localparam int FLAG_EQUAL = 4;
  localparam int FLAG_BELOW = 3;
  localparam int FLAG_ERR   = 0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_MUL = 4'd2,
    ALU_DIV = 4'd3,
    ALU_MOV = 4'd4,
    ALU_SLW = 4'd5,
    ALU_AND = 4'd6,
    ALU_OR  = 4'd7,
    ALU_SHL = 4'd8,
    ALU_SHR = 4'd9,
    ALU_NOT = 4'd10,
    ALU_CMP = 4'd11,
    ALU_JMP = 4'd12,
    ALU_BFJ = 4'd13,
    ALU_NOP = 4'd14
  } alu_op_e;

  function automatic logic op_writes_rf(alu_op_e op);
    return op inside {ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_MOV, ALU_SLW,
                      ALU_AND, ALU_OR, ALU_SHL, ALU_SHR, ALU_NOT};
  endfunction

  function automatic logic op_updates_flags(alu_op_e op);
    return op inside {ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_CMP};
  endfunction

endpackage

`default_nettype wire

// File: rtl/exec_stage_alu.sv
// ============================================================================
// exec_stage_alu : combinational ALU producing Result, RFlagsOut and Zero
// Rev 1.0
// ============================================================================
`default_nettype none

module exec_stage_alu #(
  parameter int DATA_W = 32,
  parameter int FLAG_W = exec_stage_pkg::FLAG_W
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic [DATA_W-1:0] result_o,
  output logic [FLAG_W-1:0] flags_o,
  output logic              zero_o
);
  import exec_stage_pkg::*;

  localparam int SH_W = $clog2(DATA_W);

  alu_op_e                 w_op;
  logic [DATA_W-1:0]       w_sum;
  logic [DATA_W-1:0]       w_diff;
  logic [2*DATA_W-1:0]     w_prod;

  assign w_op = alu_op_e'(op_i);

  always_comb begin
    w_sum    = a_i + b_i;
    w_diff   = a_i - b_i;
    w_prod   = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
    result_o = '0;
    flags_o  = '0;
    zero_o   = 1'b0;
    case (w_op)
      ALU_ADD: begin
        result_o          = w_sum;
        flags_o[FLAG_OVF] = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                            (w_sum[DATA_W-1] != a_i[DATA_W-1]);
      end
      ALU_SUB: begin
        result_o          = w_diff;
        flags_o[FLAG_OVF] = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                            (w_diff[DATA_W-1] != a_i[DATA_W-1]);
      end
      ALU_MUL: begin
        result_o          = w_prod[DATA_W-1:0];
        flags_o[FLAG_OVF] = |w_prod[2*DATA_W-1:DATA_W];
      end
      ALU_DIV: begin
        if (b_i == '0) flags_o[FLAG_ERR] = 1'b1;
        else           result_o          = a_i / b_i;
      end
      ALU_MOV: result_o = b_i;
      ALU_SLW: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SHL: result_o = a_i << b_i[SH_W-1:0];
      ALU_SHR: result_o = a_i >> b_i[SH_W-1:0];
      ALU_NOT: result_o = ~a_i;
      ALU_CMP: begin
        flags_o[FLAG_ABOVE] = a_i > b_i;
        flags_o[FLAG_EQUAL] = a_i == b_i;
        flags_o[FLAG_BELOW] = a_i < b_i;
      end
      default: ;
    endcase
    // BFJ: b carries {want, mask}; branch when every masked flag equals want
    if (w_op == ALU_JMP)
      zero_o = 1'b1;
    else if (w_op == ALU_BFJ)
      zero_o = ((flags_i ^ b_i[2*FLAG_W-1:FLAG_W]) & b_i[FLAG_W-1:0]) == '0;
    else
      zero_o = (result_o == '0);
  end

endmodule

`default_nettype wire

// File: rtl/exec_stage.sv
// ============================================================================
// exec_stage : execute stage with ALU, flags register and valid/ready output
// Rev 1.0
// ============================================================================
`default_nettype none

module exec_stage #(
  parameter int DATA_W = 32,
  parameter int FLAG_W = exec_stage_pkg::FLAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [4:0]        in_rd,
  input  logic [DATA_W-1:0] in_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [4:0]        out_rd,
  output logic              out_wr_en,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic [FLAG_W-1:0] flags,
  output logic [31:0]       retired
);
  import exec_stage_pkg::*;

  alu_op_e           w_op;
  logic [DATA_W-1:0] w_alu_result;
  logic [FLAG_W-1:0] w_alu_flags;
  logic              w_alu_zero;
  logic              w_accept;
  logic              w_retire;

  logic              out_valid_q,  out_valid_d;
  logic [DATA_W-1:0] result_q,     result_d;
  logic [4:0]        rd_q,         rd_d;
  logic              wr_en_q,      wr_en_d;
  logic              br_taken_q,   br_taken_d;
  logic [DATA_W-1:0] br_target_q,  br_target_d;
  logic [FLAG_W-1:0] flags_q,      flags_d;
  logic [31:0]       retired_q,    retired_d;

  exec_stage_alu #(
    .DATA_W (DATA_W),
    .FLAG_W (FLAG_W)
  ) u_alu (
    .op_i     (in_op),
    .a_i      (in_a),
    .b_i      (in_b),
    .flags_i  (flags_q),
    .result_o (w_alu_result),
    .flags_o  (w_alu_flags),
    .zero_o   (w_alu_zero)
  );

  assign w_op     = alu_op_e'(in_op);
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_retire = out_valid_q && out_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    rd_d        = rd_q;
    wr_en_d     = wr_en_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    flags_d     = flags_q;
    retired_d   = retired_q + {31'd0, w_retire};
    // flush blocks acceptance via in_ready, so it never coincides with w_accept
    if (flush) begin
      out_valid_d = 1'b0;
      wr_en_d     = 1'b0;
      br_taken_d  = 1'b0;
    end else if (w_accept) begin
      out_valid_d = 1'b1;
      result_d    = w_alu_result;
      rd_d        = in_rd;
      wr_en_d     = op_writes_rf(w_op) &&
                    !(w_op == ALU_DIV && w_alu_flags[FLAG_ERR]);
      br_taken_d  = w_alu_zero && (w_op == ALU_JMP || w_op == ALU_BFJ);
      br_target_d = in_target;
      if (op_updates_flags(w_op)) flags_d = w_alu_flags;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      wr_en_d     = 1'b0;
      br_taken_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
      wr_en_q     <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      flags_q     <= '0;
      retired_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      rd_q        <= rd_d;
      wr_en_q     <= wr_en_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      flags_q     <= flags_d;
      retired_q   <= retired_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = result_q;
  assign out_rd        = rd_q;
  assign out_wr_en     = wr_en_q;
  assign branch_taken  = br_taken_q;
  assign branch_target = br_target_q;
  assign flags         = flags_q;
  assign retired       = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_stage.sv
// ============================================================================
// tb_exec_stage : directed self-checking bench for exec_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_exec_stage;
  import exec_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b, in_target, out_result, branch_target, retired;
  logic [4:0]  in_rd, out_rd;
  logic        out_wr_en, branch_taken;
  logic [6:0]  flags;

  exec_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .in_target(in_target), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .branch_taken(branch_taken),
    .branch_target(branch_target), .flags(flags), .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference ALU from the instruction semantics, using wide integer arithmetic
  function automatic void model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [6:0] fl, output logic [31:0] r,
                                    output logic [6:0] fo, output logic taken);
    longint          s;
    longint unsigned p;
    r = 0; fo = 0; taken = 0;
    case (op)
      ALU_ADD: begin s = longint'($signed(a)) + longint'($signed(b)); r = a + b;
                     fo[6] = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      ALU_SUB: begin s = longint'($signed(a)) - longint'($signed(b)); r = a - b;
                     fo[6] = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      ALU_MUL: begin p = 64'(a) * 64'(b); r = p[31:0]; fo[6] = p > 64'hFFFF_FFFF; end
      ALU_DIV: if (b == 0) fo[0] = 1; else r = a / b;
      ALU_MOV: r = b;
      ALU_SLW: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SHL: r = a << b[4:0];
      ALU_SHR: r = a >> b[4:0];
      ALU_NOT: r = ~a;
      ALU_CMP: begin fo[5] = a > b; fo[4] = a == b; fo[3] = a < b; end
      ALU_JMP: taken = 1;
      ALU_BFJ: begin
        taken = 1;
        for (int i = 0; i < 7; i++) if (b[i] && (fl[i] != b[7+i])) taken = 0;
      end
      default: ;
    endcase
  endfunction

  logic        m_valid, m_wr, m_br;
  logic [31:0] m_result, m_tgt, m_retired;
  logic [4:0]  m_rd;
  logic [6:0]  m_flags;

  always @(posedge clk or posedge reset) begin
    logic [31:0] r;
    logic [6:0]  fo;
    logic        tk, rdy;
    if (reset) begin
      m_valid = 0; m_wr = 0; m_br = 0; m_result = 0; m_tgt = 0;
      m_retired = 0; m_rd = 0; m_flags = 0;
    end else begin
      rdy = !flush && (!m_valid || out_ready);
      if (m_valid && out_ready && !flush) m_retired = m_retired + 1;
      if (flush) m_valid = 0;
      else if (in_valid && rdy) begin
        model_alu(in_op, in_a, in_b, m_flags, r, fo, tk);
        m_valid = 1; m_result = r; m_rd = in_rd; m_tgt = in_target; m_br = tk;
        case (in_op)
          ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_MOV, ALU_SLW, ALU_AND,
          ALU_OR, ALU_SHL, ALU_SHR, ALU_NOT: m_wr = !(in_op == ALU_DIV && fo[0]);
          default: m_wr = 0;
        endcase
        if (in_op inside {ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_CMP}) m_flags = fo;
      end else if (out_ready) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready", in_ready, !flush && (!m_valid || out_ready));
      check("out_valid", out_valid, m_valid);
      check("flags", flags, m_flags);
      check("retired", retired, m_retired);
      if (m_valid) begin
        check("out_result", out_result, m_result);
        check("out_rd", out_rd, m_rd);
        check("out_wr_en", out_wr_en, m_wr);
        check("branch_taken", branch_taken, m_br);
        check("branch_target", branch_target, m_tgt);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] tgt);
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_rd = rd; in_target = tgt;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  logic [3:0]  v_op  [12] = '{ALU_MUL, ALU_MUL, ALU_MOV, ALU_SLW, ALU_AND, ALU_OR,
                              ALU_SHL, ALU_SHR, ALU_NOT, ALU_SUB, ALU_JMP, ALU_NOP};
  logic [31:0] v_a   [12] = '{32'h0001_0000, 32'd3, 32'd0, 32'hFFFF_FFFF, 32'hF0F0, 32'hF0F0,
                              32'd1, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'd0, 32'd0};
  logic [31:0] v_b   [12] = '{32'h0001_0000, 32'd5, 32'h1234, 32'd1, 32'hFF00, 32'h0F0F,
                              32'd31, 32'd4, 32'd0, 32'd1, 32'd0, 32'd0};
  logic [31:0] v_res [12] = '{32'd0, 32'd15, 32'h1234, 32'd1, 32'hF000, 32'hFFFF,
                              32'h8000_0000, 32'h0800_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                              32'd0, 32'd0};

  initial begin
    logic [31:0] r0;
    logic [6:0]  f0;
    reset = 1; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_rd = 0;
    in_target = 0; flush = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", flags, 0);
    check("rst_retired", retired, 0);
    check("rst_out_result", out_result, 0);
    reset = 0;
    #1 check("rst_in_ready", in_ready, 1);

    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd1, 0);
    check("add_result", out_result, 32'hFFFF_FFFE);
    check("add_flags", flags, 7'b1000000);
    check("add_wr_en", out_wr_en, 1);

    issue(ALU_DIV, 32'd100, 32'd0, 5'd2, 0);
    check("div0_result", out_result, 0);
    check("div0_flags", flags, 7'b0000001);
    check("div0_wr_en", out_wr_en, 0);

    issue(ALU_DIV, 32'd100, 32'd7, 5'd3, 0);
    check("div_result", out_result, 14);

    issue(ALU_CMP, 32'd5, 32'd5, 5'd4, 0);
    check("cmp_flags", flags, 7'b0010000);
    issue(ALU_BFJ, 32'd0, 32'h0810, 5'd5, 32'h40);
    check("bfj_taken", branch_taken, 1);
    check("bfj_target", branch_target, 32'h40);
    check("bfj_flags_hold", flags, 7'b0010000);
    issue(ALU_BFJ, 32'd0, 32'h0010, 5'd6, 32'h44);
    check("bfj_not_taken", branch_taken, 0);

    for (int i = 0; i < 12; i++) begin
      issue(v_op[i], v_a[i], v_b[i], 5'(i + 8), 32'h100 + i);
      check("vec_result", out_result, v_res[i]);
      if (v_op[i] == ALU_SUB) check("sub_ovf_flags", flags, 7'b1000000);
    end

    // backpressure
    issue(ALU_ADD, 32'd3, 32'd4, 5'd3, 0);
    r0 = retired;
    out_ready = 0; in_valid = 1; in_op = ALU_SUB; in_a = 10; in_b = 1; in_rd = 4;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_result", out_result, 7);
    end
    check("bp_retired_hold", retired, r0);
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check("bp_rel_retired", retired, r0 + 1);
    check("bp_rel_result", out_result, 9);
    @(posedge clk); #1;
    check("bp_drain_retired", retired, r0 + 2);
    check("bp_drain_valid", out_valid, 0);

    // flush with valid input and a held result
    issue(ALU_ADD, 32'd1, 32'd1, 5'd9, 0);
    f0 = flags; r0 = retired;
    flush = 1; in_valid = 1; in_op = ALU_CMP; in_a = 9; in_b = 9;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    check("flush_valid", out_valid, 0);
    check("flush_flags", flags, f0);
    check("flush_retired", retired, r0);

    // reset while stalled
    issue(ALU_ADD, 32'd5, 32'd6, 5'd7, 32'h99);
    out_ready = 0;
    @(posedge clk); #1;
    #2 reset = 1;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_wr_en", out_wr_en, 0);
    check("mrst_br", branch_taken, 0);
    check("mrst_result", out_result, 0);
    check("mrst_rd", out_rd, 0);
    check("mrst_target", branch_target, 0);
    check("mrst_flags", flags, 0);
    check("mrst_retired", retired, 0);
    @(posedge clk); #1;
    reset = 0; out_ready = 1;
    #1 check("mrst_in_ready", in_ready, 1);

    issue(ALU_ADD, 32'd2, 32'd3, 5'd1, 0);
    check("post_rst_add", out_result, 5);
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
